// File: rtl/pconv_stream.sv
// Pointwise (1x1) convolution stream engine: MAC, bias, rounding shift,
// optional ReLU and saturation, with valid/ready flow control and frame tracking.
module pconv_stream #(
  parameter int N              = 16,
  parameter int INPUT_CHANNEL  = 6,
  parameter int OUTPUT_CHANNEL = 32,
  parameter int INPUT_SIZE     = 6
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    ce,
  input  logic                                    relu_en,
  input  logic                                    din_vld,
  output logic                                    din_rdy,
  input  logic [INPUT_CHANNEL*N-1:0]              din,
  input  logic [OUTPUT_CHANNEL*INPUT_CHANNEL*N-1:0] weight_din,
  input  logic [OUTPUT_CHANNEL*32-1:0]            bias_din,
  input  logic [OUTPUT_CHANNEL*5-1:0]             shift_din,
  output logic [OUTPUT_CHANNEL*N-1:0]             dout,
  output logic                                    dout_vld,
  input  logic                                    dout_rdy,
  output logic                                    dout_last,
  output logic                                    frame_done,
  output logic                                    busy
);

  localparam int PIXELS  = INPUT_SIZE * INPUT_SIZE;
  localparam int ACC_RAW = 2*N + $clog2(INPUT_CHANNEL) + 1;
  localparam int ACC_W   = (ACC_RAW > 33) ? ACC_RAW : 33;
  localparam int CNT_W   = (PIXELS > 1) ? $clog2(PIXELS) : 1;

  localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W+2-N){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W+2-N){1'b1}}, {(N-1){1'b0}}};
  localparam logic [CNT_W-1:0]      LAST_PIX = CNT_W'(PIXELS - 1);

  logic advance;
  logic out_hs;

  logic                    s1_vld;
  logic signed [2*N-1:0]   s1_p     [OUTPUT_CHANNEL][INPUT_CHANNEL];
  logic signed [31:0]      s1_bias  [OUTPUT_CHANNEL];
  logic [4:0]              s1_shift [OUTPUT_CHANNEL];

  logic                    s2_vld;
  logic signed [ACC_W-1:0] s2_acc   [OUTPUT_CHANNEL];
  logic [4:0]              s2_shift [OUTPUT_CHANNEL];

  logic signed [ACC_W-1:0] acc_nx   [OUTPUT_CHANNEL];
  logic [OUTPUT_CHANNEL*N-1:0] dout_nx;
  logic signed [ACC_W:0]   round_add;
  logic signed [ACC_W:0]   rnd_sum;
  logic signed [ACC_W:0]   shifted;

  logic [CNT_W-1:0]        count;

  // Whole pipeline moves together; a stalled output freezes every stage.
  always_comb begin
    advance   = ce & (~dout_vld | dout_rdy);
    din_rdy   = advance;
    out_hs    = ce & dout_vld & dout_rdy;
    dout_last = dout_vld & (count == LAST_PIX);
    busy      = s1_vld | s2_vld | dout_vld | (count != '0);
  end

  // S1: products plus per-pixel snapshot of bias and shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
    end else if (advance) begin
      s1_vld <= din_vld;
      for (int unsigned o = 0; o < OUTPUT_CHANNEL; o++) begin
        for (int unsigned c = 0; c < INPUT_CHANNEL; c++) begin
          s1_p[o][c] <= (2*N)'($signed(din[c*N +: N])) *
                        (2*N)'($signed(weight_din[(o*INPUT_CHANNEL+c)*N +: N]));
        end
        s1_bias[o]  <= $signed(bias_din[o*32 +: 32]);
        s1_shift[o] <= shift_din[o*5 +: 5];
      end
    end
  end

  // Accumulate products and sign-extended bias at full width.
  always_comb begin
    for (int unsigned o = 0; o < OUTPUT_CHANNEL; o++) begin
      acc_nx[o] = {{(ACC_W-32){s1_bias[o][31]}}, s1_bias[o]};
      for (int unsigned c = 0; c < INPUT_CHANNEL; c++) begin
        acc_nx[o] = acc_nx[o] + {{(ACC_W-2*N){s1_p[o][c][2*N-1]}}, s1_p[o][c]};
      end
    end
  end

  // S2: accumulator register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld <= 1'b0;
    end else if (advance) begin
      s2_vld <= s1_vld;
      for (int unsigned o = 0; o < OUTPUT_CHANNEL; o++) begin
        s2_acc[o]   <= acc_nx[o];
        s2_shift[o] <= s1_shift[o];
      end
    end
  end

  // Round half up, arithmetic shift, optional ReLU, saturate to N bits.
  always_comb begin
    dout_nx   = '0;
    round_add = '0;
    rnd_sum   = '0;
    shifted   = '0;
    for (int unsigned o = 0; o < OUTPUT_CHANNEL; o++) begin
      round_add = '0;
      if (s2_shift[o] != 5'd0) round_add[s2_shift[o] - 5'd1] = 1'b1;
      rnd_sum = {s2_acc[o][ACC_W-1], s2_acc[o]} + round_add;
      shifted = rnd_sum >>> s2_shift[o];
      if (relu_en && (shifted < 0))  dout_nx[o*N +: N] = '0;
      else if (shifted > SAT_MAX)    dout_nx[o*N +: N] = SAT_MAX[N-1:0];
      else if (shifted < SAT_MIN)    dout_nx[o*N +: N] = SAT_MIN[N-1:0];
      else                           dout_nx[o*N +: N] = shifted[N-1:0];
    end
  end

  // S3: output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_vld <= 1'b0;
      dout     <= '0;
    end else if (advance) begin
      dout_vld <= s2_vld;
      if (s2_vld) dout <= dout_nx;
    end
  end

  // Frame pixel counter and end-of-frame pulse, driven by output handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      frame_done <= 1'b0;
    end else if (ce) begin
      frame_done <= out_hs & (count == LAST_PIX);
      if (out_hs) count <= (count == LAST_PIX) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pconv_stream.sv
// Directed bench for pconv_stream with 6 input and 2 output channels.
module tb_pconv_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0;
  logic        relu_en = 1'b0;
  logic        din_vld = 1'b0;
  logic        din_rdy;
  logic [95:0] din = '0;
  logic [191:0] weight_din = '0;
  logic [63:0] bias_din = '0;
  logic [9:0]  shift_din = '0;
  logic [31:0] dout;
  logic        dout_vld;
  logic        dout_rdy = 1'b1;
  logic        dout_last;
  logic        frame_done;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int wt [2][6];
  int bias [2];
  int sh [2];

  pconv_stream #(.N(16), .INPUT_CHANNEL(6), .OUTPUT_CHANNEL(2), .INPUT_SIZE(6)) dut (
    .clk(clk), .rst(rst), .ce(ce), .relu_en(relu_en),
    .din_vld(din_vld), .din_rdy(din_rdy), .din(din),
    .weight_din(weight_din), .bias_din(bias_din), .shift_din(shift_din),
    .dout(dout), .dout_vld(dout_vld), .dout_rdy(dout_rdy),
    .dout_last(dout_last), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint ch(input int o);
    return longint'($signed(dout[o*16 +: 16]));
  endfunction

  task automatic apply_cfg();
    for (int o = 0; o < 2; o++) begin
      for (int c = 0; c < 6; c++) weight_din[(o*6+c)*16 +: 16] = 16'(wt[o][c]);
      bias_din[o*32 +: 32] = 32'(bias[o]);
      shift_din[o*5 +: 5]  = 5'(sh[o]);
    end
  endtask

  task automatic set_pix(input int k);
    for (int c = 0; c < 6; c++) din[c*16 +: 16] = 16'(k);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk); rst = 1'b1; din_vld = 1'b0;
    @(negedge clk); rst = 1'b0; ce = 1'b1; dout_rdy = 1'b1;
    #1;
    check({tag, "_dout_vld"}, dout_vld, 0);
    check({tag, "_dout"}, dout, 0);
    check({tag, "_last"}, dout_last, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_din_rdy"}, din_rdy, 1);
    check({tag, "_busy"}, busy, 0);
  endtask

  // One pixel already on din; output must appear exactly 3 cycles after accept.
  task automatic one_pixel(input string tag, input longint e0, input longint e1);
    @(negedge clk); din_vld = 1'b1; dout_rdy = 1'b1; ce = 1'b1;
    #1 check({tag, "_din_rdy"}, din_rdy, 1);
    @(negedge clk); din_vld = 1'b0;
    #1 check({tag, "_vld_c1"}, dout_vld, 0);
    @(negedge clk);
    #1 check({tag, "_vld_c2"}, dout_vld, 0);
    @(negedge clk);
    #1 check({tag, "_vld_c3"}, dout_vld, 1);
    check({tag, "_ch0"}, ch(0), e0);
    check({tag, "_ch1"}, ch(1), e1);
  endtask

  // Pixel k (1..36) has every channel = k; ch0 = 6k, ch1 = 3k-10.
  task automatic run_frame(input string tag, input bit rnd, input int pause_at, input int rst_at);
    int sent = 0;
    int rcv = 0;
    int fd = 0;
    int cyc = 0;
    bit paused = 0;
    bit aborted = 0;
    logic [31:0] snap;
    logic snap_v, snap_l;
    while (rcv < 36 && !aborted && cyc < 3000) begin
      @(negedge clk); cyc++;
      if (!paused && pause_at >= 0 && rcv == pause_at) begin
        paused = 1; ce = 1'b0; dout_rdy = 1'b1;
        din_vld = (sent < 36); set_pix(sent + 1);
        #1 snap = dout; snap_v = dout_vld; snap_l = dout_last;
        check({tag, "_ce0_rdy"}, din_rdy, 0);
        repeat (4) begin
          @(negedge clk); #1;
          check({tag, "_ce0_rdy"}, din_rdy, 0);
          check({tag, "_ce0_dout"}, dout, snap);
          check({tag, "_ce0_vld"}, dout_vld, snap_v);
          check({tag, "_ce0_last"}, dout_last, snap_l);
          if (frame_done) fd++;
        end
      end else if (rst_at >= 0 && sent == rst_at) begin
        rst = 1'b1; din_vld = 1'b0; ce = 1'b1;
        @(negedge clk); rst = 1'b0;
        #1;
        check({tag, "_rst_vld"}, dout_vld, 0);
        check({tag, "_rst_busy"}, busy, 0);
        check({tag, "_rst_fd"}, frame_done, 0);
        aborted = 1;
      end else begin
        ce = 1'b1;
        dout_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        din_vld = (sent < 36); set_pix(sent + 1);
        #1;
        if (frame_done) fd++;
        if (din_vld && din_rdy) sent++;
        if (dout_vld && dout_rdy) begin
          check({tag, "_ch0"}, ch(0), 6 * (rcv + 1));
          check({tag, "_ch1"}, ch(1), 3 * (rcv + 1) - 10);
          check({tag, "_last"}, dout_last, (rcv == 35) ? 1 : 0);
          rcv++;
        end
      end
    end
    check({tag, "_timeout"}, (cyc < 3000) ? 1 : 0, 1);
    din_vld = 1'b0; ce = 1'b1; dout_rdy = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      if (frame_done) fd++;
    end
    if (aborted) begin
      check({tag, "_fd_none"}, fd, 0);
    end else begin
      check({tag, "_count"}, rcv, 36);
      check({tag, "_fd_once"}, fd, 1);
      check({tag, "_idle"}, busy, 0);
    end
  endtask

  initial begin
    do_reset("reset");

    // Basic MAC + bias: 6*1*2+3 = 15 on both channels.
    for (int o = 0; o < 2; o++) begin
      for (int c = 0; c < 6; c++) wt[o][c] = 2;
      bias[o] = 3; sh[o] = 0;
    end
    apply_cfg(); set_pix(1);
    one_pixel("basic", 15, 15);

    // Rounding: acc 7 >> 1 -> 4, acc -7 >> 1 -> -3; ReLU clamps the negative one.
    do_reset("rst2");
    for (int o = 0; o < 2; o++) begin
      for (int c = 0; c < 6; c++) wt[o][c] = 0;
      bias[o] = 0; sh[o] = 1;
    end
    wt[0][0] = 1; wt[1][0] = -1;
    apply_cfg(); din = '0; din[15:0] = 16'd7;
    one_pixel("round", 4, -3);
    do_reset("rst3");
    relu_en = 1'b1;
    one_pixel("relu", 4, 0);
    do_reset("rst4");
    relu_en = 1'b0;

    // Saturation at both rails.
    for (int o = 0; o < 2; o++) begin
      for (int c = 0; c < 6; c++) wt[o][c] = (o == 0) ? 32767 : -32767;
      bias[o] = 0; sh[o] = 0;
    end
    apply_cfg(); set_pix(32767);
    one_pixel("sat", 32767, -32768);

    // Streaming configuration: ch0 weights 1, ch1 weights c-2 with bias -10.
    do_reset("rst5");
    for (int c = 0; c < 6; c++) begin
      wt[0][c] = 1; wt[1][c] = c - 2;
    end
    bias[0] = 0; bias[1] = -10; sh[0] = 0; sh[1] = 0;
    apply_cfg();
    run_frame("stream_rnd", 1'b1, -1, -1);
    run_frame("ce_pause", 1'b0, 10, -1);
    run_frame("mid_rst", 1'b0, -1, 20);
    run_frame("after_rst", 1'b1, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
